// File: rtl/sprite_rom_arbiter_if.sv
// Sprite ROM arbiter bus.
// Bundles the requester handshake, the response path and the ROM read port.
// The slave modport is the arbiter's view of the bus.
// The master modport is the environment's view: the renderers plus the ROM instance.
interface sprite_rom_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 12
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rom_en;
  logic [ADDR_W-1:0]         rom_addr;
  logic [DATA_W-1:0]         rom_data;
  logic                      busy;

  modport slave (
    input  req, req_addr, rom_data,
    output gnt, rsp_valid, rsp_data, rom_en, rom_addr, busy
  );

  modport master (
    output req, req_addr, rom_data,
    input  gnt, rsp_valid, rsp_data, rom_en, rom_addr, busy
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// Sprite ROM arbiter.
// Shares one single-port sprite/tile ROM between NUM_REQ pixel requesters.
// Requests are granted round-robin, and the ROM enable and address are registered.
// Each read's owner rides a tag pipeline matched to the ROM latency, so the returned
// color is flagged to the requester that asked for it.
// Optional feature: define SPRITE_ARB_REQ0_PRIORITY_EN to make requester 0 an
// absolute-priority client. The remaining requesters then rotate among themselves.
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 11,
  parameter int DATA_W  = 12,
  parameter int ROM_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  sprite_rom_arbiter_if.slave bus
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Round-robin pointer: the index where the next search starts.
  logic [ID_W-1:0]    rr_ptr;

  // Result of this cycle's arbitration.
  logic               grant_any;
  logic [ID_W-1:0]    grant_id;
  logic [NUM_REQ-1:0] gnt_vec;
  logic [ADDR_W-1:0]  grant_addr;
  logic [ID_W-1:0]    ptr_next;

  // Issue stage: holds the read whose address is on rom_addr this cycle.
  logic               issue_valid;
  logic [ID_W-1:0]    issue_id;
  logic [ADDR_W-1:0]  rom_addr_q;
  logic               rom_en_q;
  logic               rom_en_next;

  // Owner tags that follow each read through the ROM's internal registers.
  logic [ROM_LAT-1:0] tag_valid;
  logic [ID_W-1:0]    tag_id [ROM_LAT];

  logic [NUM_REQ-1:0] rsp_vec;

`ifdef SPRITE_ARB_REQ0_PRIORITY_EN
  // Requester 0 wins outright. Otherwise, rotate among requesters 1..NUM_REQ-1.
  always_comb begin
    int start;
    int pos;
    logic [ID_W-1:0] idx;
    grant_any = 1'b0;
    grant_id  = '0;
    start     = 1;
    pos       = 0;
    idx       = '0;
    if (bus.req[0]) begin
      grant_any = 1'b1;
      grant_id  = '0;
    end else begin
      start = (rr_ptr == '0) ? 1 : int'(rr_ptr);
      for (int k = 0; k < NUM_REQ - 1; k++) begin
        pos = start + k;
        if (pos >= NUM_REQ) begin
          pos = pos - (NUM_REQ - 1);
        end
        idx = ID_W'(pos);
        if (!grant_any && bus.req[idx]) begin
          grant_any = 1'b1;
          grant_id  = idx;
        end
      end
    end
  end
`else
  // Search from rr_ptr, wrapping modulo NUM_REQ. The first requester found wins.
  always_comb begin
    int pos;
    logic [ID_W-1:0] idx;
    grant_any = 1'b0;
    grant_id  = '0;
    pos       = 0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      idx = ID_W'(pos);
      if (!grant_any && bus.req[idx]) begin
        grant_any = 1'b1;
        grant_id  = idx;
      end
    end
  end
`endif

  // Decode the winner into a one-hot grant, its address and the following pointer.
  always_comb begin
    gnt_vec    = '0;
    grant_addr = '0;
    ptr_next   = '0;
    if (grant_any) begin
      gnt_vec[grant_id] = 1'b1;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == ID_W'(i)) begin
        grant_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
      end
    end
    if (grant_id == ID_W'(NUM_REQ - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = grant_id + ID_W'(1);
    end
  end

  // Advance the pointer past each winner. A priority grant to requester 0 leaves it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else begin
`ifdef SPRITE_ARB_REQ0_PRIORITY_EN
      if (grant_any && (grant_id != '0)) begin
        rr_ptr <= ptr_next;
      end
`else
      if (grant_any) begin
        rr_ptr <= ptr_next;
      end
`endif
    end
  end

  // Launch the granted read. The address holds its last value while the ROM is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr_q  <= '0;
      issue_valid <= 1'b0;
      issue_id    <= '0;
    end else begin
      if (grant_any) begin
        rom_addr_q <= grant_addr;
      end
      issue_valid <= grant_any;
      issue_id    <= grant_id;
    end
  end

  // The next rom_en must cover every read that will occupy the issue stage or the early tag stages.
  always_comb begin
    rom_en_next = grant_any;
    if (ROM_LAT >= 2) begin
      rom_en_next = rom_en_next | issue_valid;
    end
    for (int i = 0; i < ROM_LAT - 2; i++) begin
      rom_en_next = rom_en_next | tag_valid[i];
    end
  end

  // Register the ROM enable so the ROM sees a clean level on every edge it needs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_en_q <= 1'b0;
    end else begin
      rom_en_q <= rom_en_next;
    end
  end

  // Shift the owner tags along with the ROM's read pipeline. This pipeline never stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        tag_id[i] <= '0;
      end
    end else begin
      tag_valid[0] <= issue_valid;
      tag_id[0]    <= issue_id;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
    end
  end

  // Flag the owner of the color that the ROM is presenting this cycle.
  always_comb begin
    rsp_vec = '0;
    if (tag_valid[ROM_LAT-1]) begin
      rsp_vec[tag_id[ROM_LAT-1]] = 1'b1;
    end
  end

  assign bus.gnt       = gnt_vec;
  assign bus.rom_en    = rom_en_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.rsp_valid = rsp_vec;
  assign bus.rsp_data  = bus.rom_data;
  assign bus.busy      = issue_valid | (|tag_valid);

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Testbench for sprite_rom_arbiter.
// Includes a two-stage registered ROM model and a scoreboard of expected responses.
// Build with SPRITE_ARB_REQ0_PRIORITY_EN defined to exercise the requester-0 priority mode.
module tb_sprite_rom_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 11;
  localparam int DATA_W  = 12;
  localparam int ROM_LAT = 2;

  typedef struct {
    logic [NUM_REQ-1:0] onehot;
    logic [DATA_W-1:0]  data;
    int                 due;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   en_cnt;

  exp_t sb[$];
  exp_t mon_e;

  logic [ADDR_W-1:0] addr_tab [NUM_REQ];
  logic [ADDR_W-1:0] rom_stage = '0;
  logic [DATA_W-1:0] rom_q     = '0;

  sprite_rom_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sprite_rom_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ROM contents: a bijection of the address, so every address returns a distinct color.
  function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
    return {a[3:0], a[10:3]} ^ 12'h5A3;
  endfunction

  // Registered ROM: the address is captured on the first enabled edge and the data on the second.
  always @(posedge clk) begin
    if (bus.rom_en) begin
      rom_stage <= bus.rom_addr;
      rom_q     <= rom_fn(rom_stage);
    end
  end
  assign bus.rom_data = rom_q;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_addr();
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_addr[i*ADDR_W +: ADDR_W] = addr_tab[i];
    end
  endtask

  // Drive one request cycle, check the grant, and queue the expected response.
  task automatic apply_stimulus(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] exp_gnt,
                                input string tag);
    int w;
    bus.req = r;
    drive_addr();
    @(negedge clk);
    check_output(tag, 32'(bus.gnt), 32'(exp_gnt));
    if (exp_gnt != '0) begin
      w = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (exp_gnt[i]) w = i;
      end
      sb.push_back('{onehot: exp_gnt, data: rom_fn(addr_tab[w]), due: cyc + 1 + ROM_LAT});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.req = '0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.req = '0;
    rst_n   = 1'b0;
    sb.delete();
    @(negedge clk);
    check_output("rst_rom_en", 32'(bus.rom_en), 32'd0);
    check_output("rst_busy", 32'(bus.busy), 32'd0);
    check_output("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Pop each scoreboard entry on its due cycle. Every other cycle must show no response.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due == cyc) begin
      mon_e = sb.pop_front();
      check_output("rsp_valid", 32'(bus.rsp_valid), 32'(mon_e.onehot));
      check_output("rsp_data", 32'(bus.rsp_data), 32'(mon_e.data));
    end else begin
      check_output("rsp_idle", 32'(bus.rsp_valid), 32'd0);
    end
  end

  // Directed sequence of scenarios.
  initial begin
    logic [NUM_REQ-1:0] exp_g;
    logic [NUM_REQ-1:0] seq_g [4];
    logic [NUM_REQ-1:0] gap_req [3];
    logic [ADDR_W-1:0]  gap_addr [3];
    int                 gap_id [3];

    for (int i = 0; i < NUM_REQ; i++) addr_tab[i] = '0;
    bus.req = '0;
    drive_addr();

    $display("[TB] reset and idle outputs");
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check_output("init_rom_en", 32'(bus.rom_en), 32'd0);
    check_output("init_rom_addr", 32'(bus.rom_addr), 32'd0);
    check_output("init_busy", 32'(bus.busy), 32'd0);
    check_output("init_gnt", 32'(bus.gnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    $display("[TB] single request from requester 1");
    addr_tab[1] = 11'h123;
    apply_stimulus(4'b0010, 4'b0010, "gnt_single");
    bus.req = '0;
    @(negedge clk);
    check_output("single_rom_addr", 32'(bus.rom_addr), 32'h123);
    check_output("single_rom_en_t1", 32'(bus.rom_en), 32'd1);
    check_output("single_busy_t1", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_output("single_rom_en_t2", 32'(bus.rom_en), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_output("single_rom_en_t3", 32'(bus.rom_en), 32'd0);
    check_output("single_busy_t3", 32'(bus.busy), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_output("single_busy_t4", 32'(bus.busy), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] all four requesters held from reset");
    do_reset();
    addr_tab[0] = 11'h010;
    addr_tab[1] = 11'h2A5;
    addr_tab[2] = 11'h3C0;
    addr_tab[3] = 11'h7FF;
    for (int k = 0; k < 8; k++) begin
`ifdef SPRITE_ARB_REQ0_PRIORITY_EN
      exp_g = 4'b0001;
`else
      exp_g = 4'(1 << (k % 4));
`endif
      apply_stimulus(4'b1111, exp_g, "gnt_all_four");
    end
`ifdef SPRITE_ARB_REQ0_PRIORITY_EN
    $display("[TB] requester 0 dropped, others rotate");
    seq_g[0] = 4'b0010;
    seq_g[1] = 4'b0100;
    seq_g[2] = 4'b1000;
    seq_g[3] = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(4'b1110, seq_g[k], "gnt_prio_rotate");
    end
`endif
    idle(4);

    $display("[TB] requester 2 streams back to back");
    for (int k = 0; k < 4; k++) begin
      addr_tab[2] = ADDR_W'(k);
      apply_stimulus(4'b0100, 4'b0100, "gnt_stream");
    end
    idle(5);

    $display("[TB] asynchronous reset with a read in flight");
    addr_tab[3] = 11'h456;
    apply_stimulus(4'b1000, 4'b1000, "gnt_pre_reset");
    bus.req = '0;
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_output("areset_rom_en", 32'(bus.rom_en), 32'd0);
    check_output("areset_busy", 32'(bus.busy), 32'd0);
    check_output("areset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(5);
    addr_tab[1] = 11'h0F0;
    apply_stimulus(4'b1010, 4'b0010, "gnt_after_reset");
    idle(4);

    $display("[TB] requests separated by idle gaps");
    gap_req[0]  = 4'b0001; gap_id[0] = 0; gap_addr[0] = 11'h0A1;
    gap_req[1]  = 4'b0010; gap_id[1] = 1; gap_addr[1] = 11'h1B2;
    gap_req[2]  = 4'b1000; gap_id[2] = 3; gap_addr[2] = 11'h2C3;
    for (int r = 0; r < 3; r++) begin
      addr_tab[gap_id[r]] = gap_addr[r];
      apply_stimulus(gap_req[r], gap_req[r], "gnt_gap");
      bus.req = '0;
      en_cnt = 0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (bus.rom_en) en_cnt++;
        check_output("gap_addr_hold", 32'(bus.rom_addr), 32'(gap_addr[r]));
        @(posedge clk);
        #1;
      end
      check_output("gap_en_cycles", 32'(en_cnt), 32'd2);
    end

    idle(4);
    check_output("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
